rv32i_writeback: RTL
====================

RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- LOAD_FIFO_DEPTH, 2, load-response buffer entries, power of two, at least 2.
- STARVE_LIMIT, 4, maximum consecutive load writes while ALU waits.
REQ-002 SHALL have these ports (name, direction, width, meaning), clk and reset first:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-low.
- alu_valid, in, 1, ALU result offered.
- alu_ready, out, 1, ALU result accepted this cycle.
- alu_data, in, 32, ALU/LUI/AUIPC/JAL link result.
- alu_rd, in, 5, destination register.
- load_valid, in, 1, load response offered.
- load_ready, out, 1, response accepted this cycle.
- load_rdata, in, 32, raw aligned memory word.
- load_addr_lo, in, 2, byte offset of load address.
- load_funct3, in, 3, load type.
- load_rd, in, 5, destination register.
- write_data, out, 32, to register file write port.
- write_register, out, 5, to register file write port.
- write_enable, out, 1, single-cycle write strobe.
- load_error, out, 1, one-cycle pulse for a misaligned or illegal load.
- wb_busy, out, 1, FIFO non-empty or a write strobe is pending.

Function
REQ-003 SHALL transfer on an interface when valid and ready are both high at the rising edge.
REQ-004 SHALL drive load_ready = FIFO not full, independent of load_valid.
REQ-005 SHALL store the raw word, offset, funct3 and rd in the FIFO; formatting happens at pop.
REQ-006 SHALL arbitrate once per cycle between the FIFO head and alu_valid; the FIFO head wins unless the starvation counter equals STARVE_LIMIT.
REQ-007 SHALL manage the starvation counter (width clog2(STARVE_LIMIT+1)) as follows:
- Increment on each load pop made while alu_valid is high.
- Clear on an ALU accept or when alu_valid is low.
- Saturate; never wrap.
REQ-008 SHALL assert alu_ready only in a cycle where the ALU wins arbitration.
REQ-009 SHALL register the winner in the output stage; write_enable is high for exactly one cycle, the cycle after the accept or pop.
REQ-010 SHALL give an ALU result accepted at edge N its write_enable in cycle N+1.
REQ-011 SHALL give a load accepted into an empty FIFO at edge N its pop at edge N+1 and write_enable in cycle N+2.
REQ-012 SHALL sustain one write per cycle with back-to-back sources.
REQ-013 SHALL format loads as follows (byte lane = load_addr_lo; half lane = load_addr_lo[1]):
- LB (000): byte lane, sign-extended.
- LH (001): half lane, sign-extended.
- LW (010): full word.
- LBU (100): byte lane, zero-extended.
- LHU (101): half lane, zero-extended.
REQ-014 SHALL treat any other funct3, LH/LHU with load_addr_lo[0]=1, or LW with load_addr_lo≠0 as an error: suppress write_enable and pulse load_error in the cycle the write would have occurred.
REQ-015 SHALL suppress write_enable when rd = 0; the entry is still consumed and the slot still counts for arbitration.
REQ-016 SHALL hold write_data and write_register at their last values when write_enable is low.
REQ-017 SHALL accept a push into a full FIFO in the same cycle as a pop, when load_ready is high; load_ready is not combinationally affected by the pop.
REQ-018 SHALL let FIFO pointers wrap modulo LOAD_FIFO_DEPTH and keep an occupancy counter for full/empty.

Reset
REQ-019 SHALL, when reset is low at an edge, do all of the following:
- Empty the FIFO.
- Clear the starvation counter.
- Set write_enable=0, load_error=0, write_data=0, write_register=0.
REQ-020 SHALL hold alu_ready=0 and load_ready=0 while reset is low; the first transfers occur at the edge after reset deasserts.
REQ-021 SHALL discard any transaction in flight when reset asserts mid-operation; no write strobe follows.

Structure
REQ-022 SHALL take the load funct3 encodings (LB, LH, LW, LBU, LHU) from the shared rv32i package as an enum typedef.
REQ-023 SHALL implement the FIFO as one sub-module, rv32i_wb_fifo, with synchronous active-low reset, push/pop, full/empty and count.
REQ-024 SHALL keep load formatting as combinational logic inside rv32i_writeback, not a separate module.

Verification
REQ-025 SHALL cover these directed scenarios (stimulus -> required response):
- ALU: alu_data=0x1234_5678, rd=5 accepted at edge 10 -> write_enable=1 in cycle 11, write_register=5, write_data=0x1234_5678.
- Loads of word 0x80FF_7F01: LB offset 3 -> 0xFFFF_FF80; LBU offset 1 -> 0x0000_007F; LH offset 2 -> 0xFFFF_80FF; LHU offset 0 -> 0x0000_7F01.
- Error: LW offset 2, rd=7 -> write_enable stays 0 and load_error pulses one cycle, two cycles after accept; LH offset 1 behaves the same.
- Starvation: continuous load_valid plus alu_valid (rd≠0), STARVE_LIMIT=4 -> exactly 4 load writes then 1 ALU write, repeating; load_ready drops while the FIFO is full.
- rd=0: ALU result with rd=0 -> alu_ready=1, no write_enable, write_register unchanged.
- Reset: reset pulled low the cycle after a load accept -> no write_enable afterwards, FIFO empty, wb_busy=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i load encodings and writeback FIFO entry layout
package rv32i_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    // funct3 kept as raw bits so illegal encodings survive until pop
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  addr_lo;
        logic [2:0]  funct3;
        logic [4:0]  rd;
    } load_entry_t;

    localparam int LOAD_ENTRY_W = $bits(load_entry_t);

endpackage

// File: rtl/rv32i_wb_fifo.sv
// rtl/rv32i_wb_fifo.sv - load-response FIFO with occupancy count, power-of-two depth
module rv32i_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 42,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // pointers wrap for free because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rv32i_writeback.sv
// rtl/rv32i_writeback.sv - register-file writeback arbiter for ALU results and buffered loads
module rv32i_writeback
    import rv32i_pkg::*;
#(
    parameter int LOAD_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [31:0] alu_data,
    input  logic [4:0]  alu_rd,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_rdata,
    input  logic [1:0]  load_addr_lo,
    input  logic [2:0]  load_funct3,
    input  logic [4:0]  load_rd,
    output logic [31:0] write_data,
    output logic [4:0]  write_register,
    output logic        write_enable,
    output logic        load_error,
    output logic        wb_busy
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH + 1);

    load_entry_t         push_entry;
    load_entry_t         head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                alu_accept;
    logic                load_pop;
    logic                load_push;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [31:0]         write_data_q, write_data_d;
    logic [4:0]          write_register_q, write_register_d;
    logic                write_enable_q, write_enable_d;
    logic                load_error_q, load_error_d;

    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [31:0]         load_fmt;
    logic                load_bad;

    assign push_entry = '{rdata: load_rdata, addr_lo: load_addr_lo,
                          funct3: load_funct3, rd: load_rd};

    assign load_ready = reset && !fifo_full;
    assign load_push  = load_valid && load_ready;

    // head wins by default; ALU takes the slot when FIFO is empty or the load stream has hogged it
    assign alu_ready  = reset && alu_valid && (fifo_empty || starve_q == STARVE_MAX);
    assign alu_accept = alu_ready;
    assign load_pop   = reset && !fifo_empty && !alu_accept;

    rv32i_wb_fifo #(
        .DEPTH (LOAD_FIFO_DEPTH),
        .WIDTH (LOAD_ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (reset),
        .push   (load_push),
        .din    (push_entry),
        .pop    (load_pop),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        case (head.addr_lo)
            2'd0:    byte_v = head.rdata[7:0];
            2'd1:    byte_v = head.rdata[15:8];
            2'd2:    byte_v = head.rdata[23:16];
            default: byte_v = head.rdata[31:24];
        endcase
        half_v   = head.addr_lo[1] ? head.rdata[31:16] : head.rdata[15:0];
        load_fmt = '0;
        load_bad = 1'b0;
        case (load_funct3_e'(head.funct3))
            F3_LB:  load_fmt = {{24{byte_v[7]}}, byte_v};
            F3_LBU: load_fmt = {24'd0, byte_v};
            F3_LH: begin
                load_fmt = {{16{half_v[15]}}, half_v};
                load_bad = head.addr_lo[0];
            end
            F3_LHU: begin
                load_fmt = {16'd0, half_v};
                load_bad = head.addr_lo[0];
            end
            F3_LW: begin
                load_fmt = head.rdata;
                load_bad = (head.addr_lo != 2'd0);
            end
            default: load_bad = 1'b1;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_accept) begin
            starve_d = '0;
        end else if (load_pop && starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // data/register only move on a real write so they hold otherwise
    always_comb begin
        write_enable_d   = 1'b0;
        load_error_d     = 1'b0;
        write_data_d     = write_data_q;
        write_register_d = write_register_q;
        if (alu_accept) begin
            if (alu_rd != 5'd0) begin
                write_enable_d   = 1'b1;
                write_data_d     = alu_data;
                write_register_d = alu_rd;
            end
        end else if (load_pop) begin
            if (load_bad) begin
                load_error_d = 1'b1;
            end else if (head.rd != 5'd0) begin
                write_enable_d   = 1'b1;
                write_data_d     = load_fmt;
                write_register_d = head.rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q         <= '0;
            write_enable_q   <= 1'b0;
            load_error_q     <= 1'b0;
            write_data_q     <= '0;
            write_register_q <= '0;
        end else begin
            starve_q         <= starve_d;
            write_enable_q   <= write_enable_d;
            load_error_q     <= load_error_d;
            write_data_q     <= write_data_d;
            write_register_q <= write_register_d;
        end
    end

    assign write_data     = write_data_q;
    assign write_register = write_register_q;
    assign write_enable   = write_enable_q;
    assign load_error     = load_error_q;
    assign wb_busy        = (fifo_count != '0) || write_enable_q;

endmodule
